// File: rtl/mbus_pkg.sv
// Shared types for the mbus read channel: FSM states, digit codes and the
// digit decoder used by the on-the-fly converter.
package mbus_pkg;

    typedef enum logic [1:0] {IDLE, REQ, RECV, DONE} state_t;

    localparam logic [1:0] DIG_POS = 2'b10;
    localparam logic [1:0] DIG_NEG = 2'b01;
    localparam logic [1:0] BS_POS  = 2'b01;
    localparam logic [1:0] BS_NEG  = 2'b11;

    // Returns the digit as a signed value in {-1, 0, +1}.
    function automatic logic signed [1:0] decode_digit(input logic [1:0] code,
                                                       input logic       borrow_save);
        decode_digit = 2'sb00;
        if (borrow_save) begin
            if (code == BS_POS)      decode_digit = 2'sb01;
            else if (code == BS_NEG) decode_digit = 2'sb11;
        end else begin
            if (code == DIG_POS)      decode_digit = 2'sb01;
            else if (code == DIG_NEG) decode_digit = 2'sb11;
        end
    endfunction

endpackage

// File: rtl/otf_converter.sv
// On-the-fly signed-digit to two's-complement converter. Q holds the value so
// far, QM holds Q-1; the result output is the post-update Q left-aligned.
module otf_converter
    import mbus_pkg::*;
#(
    parameter int W       = 9,
    parameter int ACC_MAX = 8,
    parameter int CW      = 5
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clear,
    input  logic                shift_en,
    input  logic signed [1:0]   digit,
    input  logic [CW-1:0]       count,
    output logic signed [W-1:0] result
);
    logic [W-1:0] q, qm, q_nxt, qm_nxt;
    logic [CW-1:0] shamt;

    always_comb begin
        q_nxt  = q;
        qm_nxt = qm;
        if (shift_en) begin
            case (digit)
                2'sb01: begin
                    q_nxt  = {q[W-2:0], 1'b1};
                    qm_nxt = {q[W-2:0], 1'b0};
                end
                2'sb11: begin
                    q_nxt  = {qm[W-2:0], 1'b1};
                    qm_nxt = {qm[W-2:0], 1'b0};
                end
                default: begin
                    q_nxt  = {q[W-2:0], 1'b0};
                    qm_nxt = {qm[W-2:0], 1'b1};
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q  <= '0;
            qm <= '0;
        end else if (clear) begin
            q  <= '0;
            qm <= '1;
        end else begin
            q  <= q_nxt;
            qm <= qm_nxt;
        end
    end

    // Aligning the post-update value lets the result register in the rlast beat.
    assign shamt  = CW'(ACC_MAX) - count;
    assign result = $signed(q_nxt << shamt);

endmodule

// File: rtl/mbus_digit_reader.sv
// mbus read-channel master: requests a result, converts the MSB-first digit
// stream to a left-aligned two's-complement word. MBUS_READER_TIMEOUT_EN adds a watchdog.
module mbus_digit_reader
    import mbus_pkg::*;
#(
    parameter int    RADIX_MODE     = 1,
    parameter string ENCODING_MODE  = "signed-digit",
    parameter int    ACCURATE_MAX   = 8,
    parameter int    DATA_LEN_WIDTH = 5,
    parameter int    DATA_WIDTH     = 2,
    parameter int    RESULT_WIDTH   = ACCURATE_MAX + 1,
    parameter int    TIMEOUT_CYCLES = 64
) (
    input  logic                           i_clk,
    input  logic                           i_rst,
    input  logic                           i_start,
    input  logic [DATA_LEN_WIDTH-1:0]      i_len,
    output logic                           o_busy,
    output logic                           o_mbus_rrq,
    output logic [DATA_LEN_WIDTH-1:0]      o_mbus_rlen,
    input  logic                           i_mbus_rready,
    input  logic [DATA_WIDTH-1:0]          i_mbus_rdata,
    input  logic                           i_mbus_rvalid,
    input  logic                           i_mbus_rlast,
    output logic signed [RESULT_WIDTH-1:0] o_result,
    output logic                           o_result_valid,
    output logic [DATA_LEN_WIDTH-1:0]      o_digit_cnt,
    output logic                           o_err
);
    generate
        if (RADIX_MODE != 1) begin : g_bad_radix
            $error("mbus_digit_reader: only RADIX_MODE=1 is supported");
        end
    endgenerate

    localparam logic BORROW_SAVE = (ENCODING_MODE == "borrow-save");

    state_t state, state_nxt;
    logic [DATA_LEN_WIDTH-1:0] len_q, exp_len, cnt, cnt_nxt;
    logic accept, overrun, take, finish, tmo_hit;
    logic signed [RESULT_WIDTH-1:0] conv_result;

    assign exp_len = (len_q == '0) ? DATA_LEN_WIDTH'(ACCURATE_MAX) : len_q;
    assign accept  = (state == RECV) && i_mbus_rvalid;
    assign overrun = accept && (cnt == DATA_LEN_WIDTH'(ACCURATE_MAX));
    assign take    = accept && !overrun;
    assign finish  = take && i_mbus_rlast;
    assign cnt_nxt = cnt + 1'b1;
    assign o_busy  = (state != IDLE);

`ifdef MBUS_READER_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] tmo;
    logic          stall;

    assign stall   = ((state == REQ) && !i_mbus_rready) || ((state == RECV) && !i_mbus_rvalid);
    assign tmo_hit = stall && (tmo == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge i_clk) begin
        if (i_rst || !stall) tmo <= '0;
        else                 tmo <= tmo + 1'b1;
    end
`else
    localparam int TMO_UNUSED = TIMEOUT_CYCLES;
    logic unused_tmo;
    assign unused_tmo = (TMO_UNUSED != 0);
    assign tmo_hit    = 1'b0;
`endif

    otf_converter #(.W(RESULT_WIDTH), .ACC_MAX(ACCURATE_MAX), .CW(DATA_LEN_WIDTH)) u_otf (
        .clk      (i_clk),
        .rst      (i_rst),
        .clear    (state == IDLE),
        .shift_en (take),
        .digit    (decode_digit(i_mbus_rdata[1:0], BORROW_SAVE)),
        .count    (cnt_nxt),
        .result   (conv_result)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (i_start) state_nxt = REQ;
            REQ: begin
                if (tmo_hit)            state_nxt = IDLE;
                else if (i_mbus_rready) state_nxt = RECV;
            end
            RECV: begin
                if (overrun || tmo_hit) state_nxt = IDLE;
                else if (finish)        state_nxt = DONE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state          <= IDLE;
            len_q          <= '0;
            cnt            <= '0;
            o_mbus_rrq     <= 1'b0;
            o_mbus_rlen    <= '0;
            o_result       <= '0;
            o_result_valid <= 1'b0;
            o_digit_cnt    <= '0;
            o_err          <= 1'b0;
        end else begin
            state          <= state_nxt;
            o_mbus_rrq     <= (state == REQ) && i_mbus_rready && !tmo_hit;
            o_mbus_rlen    <= ((state == REQ) && i_mbus_rready && !tmo_hit) ? len_q : '0;
            o_result_valid <= finish;
            o_err          <= overrun || tmo_hit || (finish && (cnt_nxt != exp_len));
            if ((state == IDLE) && i_start) begin
                len_q <= i_len;
                cnt   <= '0;
            end else if (take) begin
                cnt <= cnt_nxt;
            end
            if (finish) begin
                o_result    <= conv_result;
                o_digit_cnt <= cnt_nxt;
            end
        end
    end

endmodule

// File: tb/tb_mbus_digit_reader.sv
// Directed bench for mbus_digit_reader; expected result/error events are queued
// by the stimulus and checked by a monitor on every output pulse.
module tb_mbus_digit_reader;
    localparam logic [1:0] P = 2'b10, N = 2'b01, Z = 2'b00;

    logic              clk = 1'b0;
    logic              rst, start, rready, rvalid, rlast;
    logic [4:0]        len;
    logic [1:0]        rdata;
    logic              busy, rrq, res_valid, err;
    logic [4:0]        rlen, dcnt;
    logic signed [8:0] result;

    typedef struct {
        bit rv;
        bit er;
        int res;
        int cnt;
    } exp_t;
    exp_t expq[$];
    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    mbus_digit_reader dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_start        (start),
        .i_len          (len),
        .o_busy         (busy),
        .o_mbus_rrq     (rrq),
        .o_mbus_rlen    (rlen),
        .i_mbus_rready  (rready),
        .i_mbus_rdata   (rdata),
        .i_mbus_rvalid  (rvalid),
        .i_mbus_rlast   (rlast),
        .o_result       (result),
        .o_result_valid (res_valid),
        .o_digit_cnt    (dcnt),
        .o_err          (err)
    );

    task automatic check(input string nm, input logic signed [31:0] act, input logic signed [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic push(input bit rv, input bit er, input int res, input int cnt);
        exp_t e;
        e.rv = rv; e.er = er; e.res = res; e.cnt = cnt;
        expq.push_back(e);
    endtask

    // Monitor: every result/error pulse must match the oldest queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst === 1'b0 && (res_valid === 1'b1 || err === 1'b1)) begin
                if (expq.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_event: rv=%0b err=%0b result=%0d", res_valid, err, result);
                end else begin
                    e = expq.pop_front();
                    check("result_valid", {31'd0, res_valid}, {31'd0, e.rv});
                    check("err", {31'd0, err}, {31'd0, e.er});
                    if (e.rv) begin
                        check("result", result, e.res);
                        check("digit_cnt", {27'd0, dcnt}, e.cnt);
                    end
                end
            end
        end
    end

    task automatic start_read(input logic [4:0] l);
        @(posedge clk); #1;
        start = 1'b1; len = l;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_rrq(input logic [4:0] l);
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (rrq === 1'b1) begin
                check("rrq_latency", k, 1);
                check("rlen", {27'd0, rlen}, {27'd0, l});
                return;
            end
        end
        n_cmp++;
        n_bad++;
        $display("FAIL rrq_timeout: got no rrq, expected one within 20 cycles");
    endtask

    task automatic send(input string s, input bit last);
        for (int i = 0; i < s.len(); i++) begin
            @(posedge clk); #1;
            rvalid = 1'b1;
            rdata  = (s[i] == "+") ? P : (s[i] == "-") ? N : Z;
            rlast  = last && (i == s.len() - 1);
        end
        @(posedge clk); #1;
        rvalid = 1'b0; rlast = 1'b0; rdata = Z;
    endtask

    task automatic read(input logic [4:0] l, input string s, input bit last);
        start_read(l);
        wait_rrq(l);
        send(s, last);
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got no finish, expected end of test");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; start = 1'b0; len = '0; rready = 1'b1;
        rvalid = 1'b0; rlast = 1'b0; rdata = Z;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_busy", {31'd0, busy}, 0);
        check("rst_rrq", {31'd0, rrq}, 0);
        check("rst_result", result, 0);
        check("rst_valid_err", {30'd0, res_valid, err}, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        push(1, 0, 59, 8);   read(5'd0, "0+0-++0-", 1);
        push(1, 0, -255, 8); read(5'd0, "--------", 1);
        push(1, 0, 255, 8);  read(5'd0, "++++++++", 1);
        push(1, 0, 96, 3);   read(5'd3, "+-+", 1);
        check("idle_after_done", {31'd0, busy}, 0);

        // rready held low; rvalid digits and a second start during REQ must be ignored
        push(1, 0, 96, 3);
        rready = 1'b0;
        start_read(5'd3);
        rvalid = 1'b1; rdata = N; start = 1'b1; len = 5'd7;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("rrq_held_low", {31'd0, rrq}, 0);
        end
        check("busy_in_req", {31'd0, busy}, 1);
        @(posedge clk); #1;
        rready = 1'b1; rvalid = 1'b0; start = 1'b0;
        @(negedge clk); check("rrq_before", {31'd0, rrq}, 0);
        @(negedge clk); check("rrq_pulse", {31'd0, rrq}, 1);
        check("rrq_rlen", {27'd0, rlen}, 3);
        @(negedge clk); check("rrq_after", {31'd0, rrq}, 0);
        send("+-+", 1);
        repeat (3) @(posedge clk);
        #1;

        push(0, 1, 0, 0);    read(5'd0, "+++++++++", 0);
        check("idle_after_overrun", {31'd0, busy}, 0);
        push(1, 1, 136, 5);  read(5'd0, "+000+", 1);
        check("result_hold", result, 136);

        // reset in the middle of a transfer
        start_read(5'd0);
        wait_rrq(5'd0);
        send("+-0+", 0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("midrst_busy", {31'd0, busy}, 0);
        check("midrst_rrq", {31'd0, rrq}, 0);
        check("midrst_result", result, 0);
        check("midrst_cnt", {27'd0, dcnt}, 0);
        check("midrst_valid_err", {30'd0, res_valid, err}, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        push(1, 0, -64, 2);  read(5'd2, "-+", 1);

`ifdef MBUS_READER_TIMEOUT_EN
        push(0, 1, 0, 0);
        start_read(5'd3);
        wait_rrq(5'd3);
        send("+", 0);
        repeat (70) @(posedge clk);
        #1;
        check("idle_after_timeout", {31'd0, busy}, 0);
`endif

        repeat (5) @(posedge clk);
        @(negedge clk);
        check("queue_empty", expq.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
